pipeline_run_controller: RTL and testbench

Synthesisable run-control and statistics block for the pipelined processor. It sequences the core out of reset, counts cycles and retired instructions, detects the halt instruction at commit, and enforces a cycle-budget watchdog. It replaces fixed-delay simulation stop logic with a deterministic `done`/`timeout` indication and sits beside `pipeline_top_module`, driving its reset and observing its commit stage.

---
 rtl/pipeline_run_controller.sv | 180 ++++++++++++++++++
 tb/tb_pipeline_run_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_run_controller.sv
// pipeline_run_controller
// Run-control and statistics block for the pipelined processor. It holds the
// core in reset for RESET_CYCLES edges after `reset` drops, then enables it and
// counts run cycles and retired instructions until a halt instruction commits
// or the cycle budget MAX_CYCLES expires.
//
// Optional feature macro: RUN_CTRL_BRANCH_STATS_EN
//   defined   -> branch_count counts taken branches seen while running
//   undefined -> branch_count is tied to zero, is_Branch_Taken is ignored
module pipeline_run_controller #(
    parameter int PC_WIDTH     = 10,
    parameter int IR_WIDTH     = 32,
    parameter int CNT_WIDTH    = 32,
    parameter int RESET_CYCLES = 4,
    parameter int MAX_CYCLES   = 1000,
    parameter int OPC_MSB      = 31,
    parameter int OPC_LSB      = 27,
    parameter logic [OPC_MSB-OPC_LSB:0] HALT_OPCODE = 5'b11111
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 commit_valid,
    input  logic [IR_WIDTH-1:0]  commit_ir,
    input  logic [PC_WIDTH-1:0]  commit_pc,
    input  logic                 is_Branch_Taken,
    output logic                 core_reset,
    output logic                 run,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] retired_count,
    output logic [PC_WIDTH-1:0]  last_pc,
    output logic                 done,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] branch_count
);

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        RUN       = 2'd1,
        HALTED    = 2'd2,
        TIMED_OUT = 2'd3
    } state_t;

    // Hold counter only needs to reach RESET_CYCLES-1.
    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]    HOLD_LAST   = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [HOLD_W-1:0]    HOLD_ONE    = {{(HOLD_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CYCLE_LIMIT = CNT_WIDTH'(MAX_CYCLES);

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : (v + CNT_ONE);
    endfunction

    state_t                state_q,         state_d;
    logic [HOLD_W-1:0]     hold_cnt_q,      hold_cnt_d;
    logic [CNT_WIDTH-1:0]  cycle_count_q,   cycle_count_d;
    logic [CNT_WIDTH-1:0]  retired_count_q, retired_count_d;
    logic [CNT_WIDTH-1:0]  branch_count_q,  branch_count_d;
    logic [PC_WIDTH-1:0]   last_pc_q,       last_pc_d;
    logic                  core_reset_q,    core_reset_d;
    logic                  run_q,           run_d;
    logic                  done_q,          done_d;
    logic                  timeout_q,       timeout_d;
    logic                  halt_commit;
    logic                  branch_inc;

    // Only the opcode field is decoded; the remaining instruction bits are
    // intentionally ignored.
    logic unused_inputs;
    assign unused_inputs = ^{commit_ir, is_Branch_Taken};

    assign halt_commit = commit_valid && (commit_ir[OPC_MSB:OPC_LSB] == HALT_OPCODE);

`ifdef RUN_CTRL_BRANCH_STATS_EN
    assign branch_inc = is_Branch_Taken;
`else
    assign branch_inc = 1'b0;
`endif

    // Next-state and next-output computation; every register holds by default.
    always_comb begin
        state_d         = state_q;
        hold_cnt_d      = hold_cnt_q;
        cycle_count_d   = cycle_count_q;
        retired_count_d = retired_count_q;
        branch_count_d  = branch_count_q;
        last_pc_d       = last_pc_q;
        core_reset_d    = core_reset_q;
        run_d           = run_q;
        done_d          = done_q;
        timeout_d       = timeout_q;

        case (state_q)
            HOLD: begin
                // The edge that sees the last hold count releases the core,
                // so core_reset is high for exactly RESET_CYCLES edges.
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d      = RUN;
                    core_reset_d = 1'b0;
                    run_d        = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_ONE;
                end
            end

            RUN: begin
                cycle_count_d = sat_inc(cycle_count_q);
                if (commit_valid) begin
                    retired_count_d = sat_inc(retired_count_q);
                    last_pc_d       = commit_pc;
                end
                if (branch_inc) begin
                    branch_count_d = sat_inc(branch_count_q);
                end
                // A halt commit takes priority over a simultaneous budget expiry.
                if (halt_commit) begin
                    state_d = HALTED;
                    run_d   = 1'b0;
                    done_d  = 1'b1;
                end else if (cycle_count_d == CYCLE_LIMIT) begin
                    state_d   = TIMED_OUT;
                    run_d     = 1'b0;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end

            HALTED, TIMED_OUT: begin
                // Terminal: everything frozen until reset.
            end

            default: begin
                state_d      = HOLD;
                hold_cnt_d   = '0;
                core_reset_d = 1'b1;
                run_d        = 1'b0;
                done_d       = 1'b0;
                timeout_d    = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset to the hold condition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= HOLD;
            hold_cnt_q      <= '0;
            cycle_count_q   <= '0;
            retired_count_q <= '0;
            branch_count_q  <= '0;
            last_pc_q       <= '0;
            core_reset_q    <= 1'b1;
            run_q           <= 1'b0;
            done_q          <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            hold_cnt_q      <= hold_cnt_d;
            cycle_count_q   <= cycle_count_d;
            retired_count_q <= retired_count_d;
            branch_count_q  <= branch_count_d;
            last_pc_q       <= last_pc_d;
            core_reset_q    <= core_reset_d;
            run_q           <= run_d;
            done_q          <= done_d;
            timeout_q       <= timeout_d;
        end
    end

    assign core_reset    = core_reset_q;
    assign run           = run_q;
    assign cycle_count   = cycle_count_q;
    assign retired_count = retired_count_q;
    assign last_pc       = last_pc_q;
    assign done          = done_q;
    assign timeout       = timeout_q;
    assign branch_count  = branch_count_q;

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Testbench for pipeline_run_controller: directed run scenarios with random
// commit traffic, compared every cycle against a behavioural run model.
module tb_pipeline_run_controller;

    localparam int PC_W  = 10;
    localparam int IR_W  = 32;
    localparam int CNT_W = 32;
    localparam int RST_C = 4;
    localparam int MAXC  = 50;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    logic              clk;
    logic              reset;
    logic              commit_valid;
    logic [IR_W-1:0]   commit_ir;
    logic [PC_W-1:0]   commit_pc;
    logic              is_Branch_Taken;
    logic              core_reset;
    logic              run;
    logic [CNT_W-1:0]  cycle_count;
    logic [CNT_W-1:0]  retired_count;
    logic [PC_W-1:0]   last_pc;
    logic              done;
    logic              timeout;
    logic [CNT_W-1:0]  branch_count;

    int total = 0;
    int bad   = 0;

    // Reference model of the run: edges of reset hold left, running flag,
    // finished flags and plain integer statistics.
    int        m_hold_left;
    bit        m_running;
    bit        m_done;
    bit        m_timeout;
    longint    m_cyc;
    longint    m_ret;
    longint    m_brc;
    logic [PC_W-1:0] m_lpc;

    pipeline_run_controller #(
        .PC_WIDTH    (PC_W),
        .IR_WIDTH    (IR_W),
        .CNT_WIDTH   (CNT_W),
        .RESET_CYCLES(RST_C),
        .MAX_CYCLES  (MAXC),
        .OPC_MSB     (31),
        .OPC_LSB     (27),
        .HALT_OPCODE (5'b11111)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .commit_valid   (commit_valid),
        .commit_ir      (commit_ir),
        .commit_pc      (commit_pc),
        .is_Branch_Taken(is_Branch_Taken),
        .core_reset     (core_reset),
        .run            (run),
        .cycle_count    (cycle_count),
        .retired_count  (retired_count),
        .last_pc        (last_pc),
        .done           (done),
        .timeout        (timeout),
        .branch_count   (branch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ".core_reset"},    64'(core_reset),    64'(m_hold_left > 0));
        chk({where, ".run"},           64'(run),           64'(m_running));
        chk({where, ".done"},          64'(done),          64'(m_done));
        chk({where, ".timeout"},       64'(timeout),       64'(m_timeout));
        chk({where, ".cycle_count"},   64'(cycle_count),   64'(m_cyc));
        chk({where, ".retired_count"}, 64'(retired_count), 64'(m_ret));
        chk({where, ".last_pc"},       64'(last_pc),       64'(m_lpc));
        chk({where, ".branch_count"},  64'(branch_count),  64'(m_brc));
    endtask

    task automatic model_reset();
        m_hold_left = RST_C;
        m_running   = 1'b0;
        m_done      = 1'b0;
        m_timeout   = 1'b0;
        m_cyc       = 0;
        m_ret       = 0;
        m_brc       = 0;
        m_lpc       = '0;
    endtask

    // What one rising edge does to the run, from the block's rules.
    task automatic model_edge(input bit cv, input logic [IR_W-1:0] ir,
                              input logic [PC_W-1:0] pc, input bit br);
        logic [4:0] opc;
        opc = ir[31:27];
        if (m_hold_left > 0) begin
            m_hold_left--;
            if (m_hold_left == 0) m_running = 1'b1;
        end else if (m_running) begin
            if (m_cyc < CNT_MAX) m_cyc++;
            if (cv) begin
                if (m_ret < CNT_MAX) m_ret++;
                m_lpc = pc;
            end
`ifdef RUN_CTRL_BRANCH_STATS_EN
            if (br && m_brc < CNT_MAX) m_brc++;
`endif
            if (cv && opc == 5'b11111) begin
                m_running = 1'b0;
                m_done    = 1'b1;
            end else if (m_cyc == MAXC) begin
                m_running = 1'b0;
                m_done    = 1'b1;
                m_timeout = 1'b1;
            end
        end
    endtask

    // Called at a falling edge; drives inputs, lets one rising edge pass,
    // and compares at the following falling edge.
    task automatic step(input bit cv, input logic [IR_W-1:0] ir,
                        input logic [PC_W-1:0] pc, input bit br);
        commit_valid    = cv;
        commit_ir       = ir;
        commit_pc       = pc;
        is_Branch_Taken = br;
        @(posedge clk);
        model_edge(cv, ir, pc, br);
        @(negedge clk);
        check_all("step");
    endtask

    function automatic logic [IR_W-1:0] rand_ir();
        logic [IR_W-1:0] v;
        v = $urandom;
        if (v[31:27] == 5'b11111) v[27] = 1'b0;
        return v;
    endfunction

    function automatic logic [IR_W-1:0] halt_ir();
        logic [IR_W-1:0] v;
        v = $urandom;
        v[31:27] = 5'b11111;
        return v;
    endfunction

    task automatic step_rand_nohalt();
        step(1'($urandom), rand_ir(), PC_W'($urandom), 1'($urandom));
    endtask

    task automatic step_rand_any();
        step(1'($urandom), IR_W'($urandom), PC_W'($urandom), 1'($urandom));
    endtask

    // Called at a falling edge; asserts reset between edges, checks the
    // immediate effect, holds it over one edge and releases it.
    task automatic do_reset(input string where);
        reset = 1'b1;
        #1;
        model_reset();
        check_all({where, ".reset_imm"});
        @(posedge clk);
        @(negedge clk);
        check_all({where, ".reset_held"});
        reset = 1'b0;
    endtask

    task automatic hold_phase(input string where);
        for (int i = 0; i < RST_C; i++) step_rand_any();
        chk({where, ".run_after_hold"},   64'(run),         64'd1);
        chk({where, ".cycle_after_hold"}, 64'(cycle_count), 64'd0);
    endtask

    initial begin
        int guard;
        reset           = 1'b1;
        commit_valid    = 1'b0;
        commit_ir       = '0;
        commit_pc       = '0;
        is_Branch_Taken = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset release and hold sequencing.
        do_reset("por");
        chk("por.core_reset_high", 64'(core_reset), 64'd1);
        hold_phase("por");

        // Normal halt: five commits, the last one the halt at PC 0x012,
        // with three taken branches along the way.
        step(1'b1, rand_ir(), 10'h003, 1'b0);
        step(1'b0, rand_ir(), 10'h3ff, 1'b1);
        step(1'b1, rand_ir(), 10'h005, 1'b1);
        step(1'b1, rand_ir(), 10'h007, 1'b0);
        step(1'b0, halt_ir(), 10'h155, 1'b0);
        step(1'b1, rand_ir(), 10'h009, 1'b1);
        step(1'b1, halt_ir(), 10'h012, 1'b0);
        chk("halt.retired",  64'(retired_count), 64'd5);
        chk("halt.last_pc",  64'(last_pc),       64'h012);
        chk("halt.done",     64'(done),          64'd1);
        chk("halt.timeout",  64'(timeout),       64'd0);
        chk("halt.run",      64'(run),           64'd0);
        chk("halt.cycles",   64'(cycle_count),   64'd7);
`ifdef RUN_CTRL_BRANCH_STATS_EN
        chk("halt.branches", 64'(branch_count),  64'd3);
`else
        chk("halt.branches", 64'(branch_count),  64'd0);
`endif
        for (int i = 0; i < 20; i++) step_rand_any();
        chk("halt.frozen_retired", 64'(retired_count), 64'd5);

        // Watchdog: random non-halt traffic until the budget expires.
        do_reset("wd");
        hold_phase("wd");
        for (int i = 0; i < MAXC; i++) step_rand_nohalt();
        chk("wd.cycles",  64'(cycle_count), 64'(MAXC));
        chk("wd.done",    64'(done),        64'd1);
        chk("wd.timeout", 64'(timeout),     64'd1);
        for (int i = 0; i < 5; i++) step_rand_any();

        // Halt commit on the very edge the budget would expire.
        do_reset("sim");
        hold_phase("sim");
        for (int i = 0; i < MAXC - 1; i++) step(1'b0, halt_ir(), PC_W'($urandom), 1'b0);
        step(1'b1, halt_ir(), 10'h2a5, 1'b0);
        chk("sim.cycles",  64'(cycle_count), 64'(MAXC));
        chk("sim.done",    64'(done),        64'd1);
        chk("sim.timeout", 64'(timeout),     64'd0);
        chk("sim.last_pc", 64'(last_pc),     64'h2a5);

        // Mid-run reset at cycle 17, then a fresh random run.
        do_reset("mid");
        hold_phase("mid");
        for (int i = 0; i < 17; i++) step_rand_nohalt();
        chk("mid.cycles_before", 64'(cycle_count), 64'd17);
        do_reset("midrst");
        hold_phase("midrst");
        guard = 0;
        while (!m_done && guard < 2 * MAXC) begin
            if ($urandom_range(0, 19) == 0)
                step(1'b1, halt_ir(), PC_W'($urandom), 1'($urandom));
            else
                step_rand_nohalt();
            guard++;
        end
        chk("rand.finished", 64'(done), 64'd1);
        for (int i = 0; i < 5; i++) step_rand_any();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
